// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each access takes one ACCESS cycle plus one DONE cycle, and every output is registered.
module dmem_arbiter #(
    parameter int ADDR_BITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        we_a,
    input  logic        we_b,
    input  logic [31:0] addr_a,
    input  logic [31:0] addr_b,
    input  logic [31:0] wdata_a,
    input  logic [31:0] wdata_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        done_a,
    output logic        done_b,
    output logic        err_a,
    output logic        err_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] endereco,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;    // high when B holds the most recent grant
    logic        owner_b_q, owner_b_d;
    logic        we_q, we_d;
    logic        oor_q, oor_d;
    logic        gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic        done_a_q, done_a_d, done_b_q, done_b_d;
    logic        err_a_q, err_a_d, err_b_q, err_b_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [31:0] endereco_q, endereco_d, write_data_q, write_data_d;
    logic [31:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic        busy_q, busy_d;

    logic        win_b, sel_we, sel_oor;
    logic [31:0] sel_addr, sel_wdata, rd_val;

    always_comb begin
        win_b     = (req_a && req_b) ? !last_b_q : req_b;
        sel_we    = win_b ? we_b : we_a;
        sel_addr  = win_b ? addr_b : addr_a;
        sel_wdata = win_b ? wdata_b : wdata_a;
        sel_oor   = (sel_addr[31:ADDR_BITS] != '0);
        rd_val    = oor_q ? 32'd0 : read_data;
    end

    always_comb begin
        state_d      = state_q;
        last_b_d     = last_b_q;
        owner_b_d    = owner_b_q;
        we_d         = we_q;
        oor_d        = oor_q;
        gnt_a_d      = 1'b0;
        gnt_b_d      = 1'b0;
        done_a_d     = 1'b0;
        done_b_d     = 1'b0;
        err_a_d      = 1'b0;
        err_b_d      = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        endereco_d   = 32'd0;
        write_data_d = 32'd0;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE, DONE: begin
                if (req_a || req_b) begin
                    state_d     = ACCESS;
                    busy_d      = 1'b1;
                    last_b_d    = win_b;
                    owner_b_d   = win_b;
                    we_d        = sel_we;
                    oor_d       = sel_oor;
                    gnt_a_d     = !win_b;
                    gnt_b_d     = win_b;
                    mem_read_d  = !sel_oor && !sel_we;
                    mem_write_d = !sel_oor && sel_we;
                    if (!sel_oor) begin
                        endereco_d   = sel_addr;
                        write_data_d = sel_we ? sel_wdata : 32'd0;
                    end
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            ACCESS: begin
                state_d  = DONE;
                busy_d   = 1'b1;
                done_a_d = !owner_b_q;
                done_b_d = owner_b_q;
                err_a_d  = !owner_b_q && oor_q;
                err_b_d  = owner_b_q && oor_q;
                if (!we_q) begin
                    if (owner_b_q) rdata_b_d = rd_val;
                    else           rdata_a_d = rd_val;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_b_q     <= 1'b1;
            owner_b_q    <= 1'b0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            done_a_q     <= 1'b0;
            done_b_q     <= 1'b0;
            err_a_q      <= 1'b0;
            err_b_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            endereco_q   <= 32'd0;
            write_data_q <= 32'd0;
            rdata_a_q    <= 32'd0;
            rdata_b_q    <= 32'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_b_q     <= last_b_d;
            owner_b_q    <= owner_b_d;
            we_q         <= we_d;
            oor_q        <= oor_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            done_a_q     <= done_a_d;
            done_b_q     <= done_b_d;
            err_a_q      <= err_a_d;
            err_b_q      <= err_b_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            endereco_q   <= endereco_d;
            write_data_q <= write_data_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt_a      = gnt_a_q;
    assign gnt_b      = gnt_b_q;
    assign done_a     = done_a_q;
    assign done_b     = done_b_q;
    assign err_a      = err_a_q;
    assign err_b      = err_b_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign endereco   = endereco_q;
    assign write_data = write_data_q;
    assign rdata_a    = rdata_a_q;
    assign rdata_b    = rdata_b_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios, followed by random traffic checked against a
// transaction-level model that holds the expected memory contents and grant order.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 0, req_b = 0, we_a = 0, we_b = 0;
    logic [31:0] addr_a = 0, addr_b = 0, wdata_a = 0, wdata_b = 0;
    logic        gnt_a, gnt_b, done_a, done_b, err_a, err_b;
    logic [31:0] rdata_a, rdata_b, endereco, write_data, read_data;
    logic        mem_read, mem_write, busy;

    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_idx = 5'd0;
    logic [31:0] pre_val = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter #(.ADDR_BITS(5)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .err_a(err_a), .err_b(err_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .mem_read(mem_read), .mem_write(mem_write), .endereco(endereco),
        .write_data(write_data), .read_data(read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge; the preload port fills it during reset.
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (mem_write) mem[endereco[4:0]] <= write_data;
    end
    assign read_data = mem[endereco[4:0]];

    task automatic idle_inputs();
        req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            pre_en = 1'b1; pre_idx = 5'(i);
            pre_val = (i == 3) ? 32'd2 : 32'(i * 10);
            ref_mem[i] = pre_val;
        end
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({gnt_a, gnt_b, done_a, done_b, err_a, err_b} !== 6'b0) begin
            n_bad++; $display("FAIL reset_pulses got %b want 000000", {gnt_a, gnt_b, done_a, done_b, err_a, err_b});
        end
        n_cmp++;
        if ({mem_read, mem_write, busy} !== 3'b0) begin
            n_bad++; $display("FAIL reset_strobes got %b want 000", {mem_read, mem_write, busy});
        end
        n_cmp++;
        if ({endereco, write_data, rdata_a, rdata_b} !== 128'd0) begin
            n_bad++; $display("FAIL reset_data got %h %h %h %h want all zero", endereco, write_data, rdata_a, rdata_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        req_a = 1; we_a = 0; addr_a = 32'd1;
        @(negedge clk);
        n_cmp++;
        if ({gnt_a, gnt_b, mem_read, mem_write, busy} !== 5'b10101 || endereco !== 32'd1) begin
            n_bad++; $display("FAIL single_access got gnt/strb/busy=%b addr=%0d want 10101 addr=1", {gnt_a, gnt_b, mem_read, mem_write, busy}, endereco);
        end
        req_a = 0;
        @(negedge clk);
        n_cmp++;
        if ({done_a, err_a, mem_read} !== 3'b100 || rdata_a !== 32'd10) begin
            n_bad++; $display("FAIL single_done got done/err/rd=%b rdata_a=%0d want 100 rdata_a=10", {done_a, err_a, mem_read}, rdata_a);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        req_b = 1; we_b = 1; addr_b = 32'd12; wdata_b = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++;
        if ({gnt_b, mem_write, mem_read} !== 3'b110 || endereco !== 32'd12 || write_data !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL wr_access got %b addr=%0d wd=%h want 110 addr=12 wd=deadbeef", {gnt_b, mem_write, mem_read}, endereco, write_data);
        end
        ref_mem[12] = 32'hDEADBEEF;
        we_b = 0; wdata_b = 0;
        @(negedge clk);
        n_cmp++;
        if (done_b !== 1'b1 || mem_write !== 1'b0) begin
            n_bad++; $display("FAIL wr_done got done_b=%b mem_write=%b want 1 0", done_b, mem_write);
        end
        @(negedge clk);
        n_cmp++;
        if (gnt_b !== 1'b1 || mem_read !== 1'b1) begin
            n_bad++; $display("FAIL rd_gnt got gnt_b=%b mem_read=%b want 1 1", gnt_b, mem_read);
        end
        req_b = 0;
        @(negedge clk);
        n_cmp++;
        if (done_b !== 1'b1 || rdata_b !== 32'hDEADBEEF || rdata_a !== 32'd10) begin
            n_bad++; $display("FAIL wr_rd_data got done_b=%b rdata_b=%h rdata_a=%0d want 1 deadbeef 10", done_b, rdata_b, rdata_a);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        reset = 1;
        req_a = 1; we_a = 0; addr_a = 32'd1;
        req_b = 1; we_b = 0; addr_b = 32'd2;
        @(negedge clk);
        reset = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt_a, gnt_b} !== {k % 4 == 1, k % 4 == 3}) begin
                n_bad++; $display("FAIL contention_c%0d got gnt_a/b=%b%b want %b%b", k, gnt_a, gnt_b, k % 4 == 1, k % 4 == 3);
            end
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (rdata_a !== 32'd10 || rdata_b !== 32'd20) begin
            n_bad++; $display("FAIL contention_data got %0d %0d want 10 20", rdata_a, rdata_b);
        end
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        req_a = 1; we_a = 0; addr_a = 32'd32;
        @(negedge clk);
        n_cmp++;
        if (gnt_a !== 1'b1 || mem_read !== 1'b0 || endereco !== 32'd0) begin
            n_bad++; $display("FAIL oor_access got gnt_a=%b mem_read=%b addr=%0d want 1 0 0", gnt_a, mem_read, endereco);
        end
        req_a = 0;
        @(negedge clk);
        n_cmp++;
        if ({done_a, err_a} !== 2'b11 || rdata_a !== 32'd0) begin
            n_bad++; $display("FAIL oor_done got done/err=%b rdata_a=%0d want 11 0", {done_a, err_a}, rdata_a);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        req_b = 1; we_b = 1; addr_b = 32'd3; wdata_b = 32'h55;
        @(negedge clk);
        n_cmp++;
        if (gnt_b !== 1'b1 || mem_write !== 1'b1) begin
            n_bad++; $display("FAIL midwr_access got gnt_b=%b mem_write=%b want 1 1", gnt_b, mem_write);
        end
        idle_inputs();
        #2 reset = 1;
        #1;
        n_cmp++;
        if (mem_write !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL midwr_async got mem_write=%b busy=%b want 0 0", mem_write, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (mem[3] !== 32'd2 || done_b !== 1'b0) begin
            n_bad++; $display("FAIL midwr_mem got mem3=%h done_b=%b want 2 0", mem[3], done_b);
        end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        req_a = 1; we_a = 0; addr_a = 32'd5;
        @(negedge clk);
        n_cmp++;
        if (gnt_a !== 1'b1) begin
            n_bad++; $display("FAIL b2b_gnt_a got %b want 1", gnt_a);
        end
        req_a = 0; req_b = 1; we_b = 0; addr_b = 32'd12;
        @(negedge clk);
        n_cmp++;
        if ({done_a, gnt_b} !== 2'b10 || rdata_a !== 32'd50) begin
            n_bad++; $display("FAIL b2b_done_a got done_a/gnt_b=%b rdata_a=%0d want 10 50", {done_a, gnt_b}, rdata_a);
        end
        @(negedge clk);
        n_cmp++;
        if ({gnt_b, done_a} !== 2'b10) begin
            n_bad++; $display("FAIL b2b_gnt_b got gnt_b/done_a=%b want 10", {gnt_b, done_a});
        end
        req_b = 0;
        @(negedge clk);
        n_cmp++;
        if (done_b !== 1'b1 || rdata_b !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL b2b_done_b got done_b=%b rdata_b=%h want 1 deadbeef", done_b, rdata_b);
        end
        @(negedge clk);
    endtask

    task automatic new_req(output logic rq, output logic we, output logic [31:0] ad, output logic [31:0] wd);
        rq = ($urandom_range(0, 3) != 0);
        we = 1'($urandom_range(0, 1));
        ad = ($urandom_range(0, 7) == 0) ? ($urandom | (32'd1 << $urandom_range(5, 31)))
                                         : 32'($urandom_range(0, 31));
        wd = $urandom;
    endtask

    task automatic test_random();
        int          g_cyc;
        logic        g_b, g_we, g_oor, last_b_m, wb, acc, dn;
        logic [31:0] g_addr, g_wdata, g_rd, e_rda, e_rdb;
        logic [5:0]  e_pulse;
        g_cyc = -10; g_b = 0; g_we = 0; g_oor = 0; g_addr = 0; g_wdata = 0; g_rd = 0;
        last_b_m = 1; e_rda = 0; e_rdb = 0;
        idle_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = (c == g_cyc);
            dn  = (c == g_cyc + 1);
            if (dn && !g_we) begin
                if (g_b) e_rdb = g_rd;
                else     e_rda = g_rd;
            end
            e_pulse = {acc && !g_b, acc && g_b, dn && !g_b, dn && g_b, dn && !g_b && g_oor, dn && g_b && g_oor};
            n_cmp++;
            if ({gnt_a, gnt_b, done_a, done_b, err_a, err_b} !== e_pulse) begin
                n_bad++; $display("FAIL rnd_pulses c%0d got %b want %b", c, {gnt_a, gnt_b, done_a, done_b, err_a, err_b}, e_pulse);
            end
            n_cmp++;
            if ({mem_read, mem_write, busy} !== {acc && !g_oor && !g_we, acc && !g_oor && g_we, acc || dn}) begin
                n_bad++; $display("FAIL rnd_strobes c%0d got %b want %b", c, {mem_read, mem_write, busy}, {acc && !g_oor && !g_we, acc && !g_oor && g_we, acc || dn});
            end
            n_cmp++;
            if (endereco !== ((acc && !g_oor) ? g_addr : 32'd0) || write_data !== ((acc && !g_oor && g_we) ? g_wdata : 32'd0)) begin
                n_bad++; $display("FAIL rnd_membus c%0d got addr=%h wd=%h want addr=%h wd=%h", c, endereco, write_data, (acc && !g_oor) ? g_addr : 32'd0, (acc && !g_oor && g_we) ? g_wdata : 32'd0);
            end
            n_cmp++;
            if (rdata_a !== e_rda || rdata_b !== e_rdb) begin
                n_bad++; $display("FAIL rnd_rdata c%0d got %h %h want %h %h", c, rdata_a, rdata_b, e_rda, e_rdb);
            end
            if (c >= 590) begin
                req_a = 0; req_b = 0;
            end else begin
                if (gnt_a || !req_a) new_req(req_a, we_a, addr_a, wdata_a);
                if (gnt_b || !req_b) new_req(req_b, we_b, addr_b, wdata_b);
            end
            // Transaction-level model: a grant can start only once the previous access has reached its done cycle.
            if ((req_a || req_b) && c >= g_cyc + 1) begin
                wb       = (req_a && req_b) ? !last_b_m : req_b;
                last_b_m = wb;
                g_cyc    = c + 1;
                g_b      = wb;
                g_we     = wb ? we_b : we_a;
                g_addr   = wb ? addr_b : addr_a;
                g_wdata  = wb ? wdata_b : wdata_a;
                g_oor    = (g_addr / 32) != 0;
                if (!g_oor && g_we) ref_mem[g_addr % 32] = g_wdata;
                g_rd     = g_oor ? 32'd0 : ref_mem[g_addr % 32];
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        preload();
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
